// File: rtl/textmode_timing_gen.sv
// textmode_timing_gen
//   Parametrised raster timing generator for the text-mode display path.
//   Walks a pixel position (hcnt, vcnt) held PIX_DIV clocks each and decodes
//   display enable, syncs, text cell / in-cell coordinates, line and frame
//   strobes and a blink phase. All outputs are registered and decoded from
//   the next-state position, so they always match the current position.
//
//   Optional feature macro: TEXTMODE_TIMING_CURSOR_EN
//     adds parameters CUR_START/CUR_END, inputs cur_col/cur_row/cur_on and
//     the registered output cursor.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   pix_en       high in the last clk of each pixel period
//   de           display enable (active pixel)
//   hsync/vsync  syncs, asserted level HSYNC_POL / VSYNC_POL
//   txtcol       text column (truncated to COL_W)
//   txtrow       text row (truncated to ROW_W)
//   chrcol       pixel within cell
//   chrrow       line within cell
//   line_start   level, position hcnt==0
//   frame_start  level, position hcnt==0 and vcnt==0
//   blink        blink phase
//   cur_col/cur_row/cur_on/cursor  (cursor build only)
module textmode_timing_gen #(
    parameter int PIX_DIV      = 2,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit HSYNC_POL    = 1'b0,
    parameter bit VSYNC_POL    = 1'b0,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int COL_W        = 7,
    parameter int ROW_W        = 5,
`ifdef TEXTMODE_TIMING_CURSOR_EN
    parameter int CUR_START    = 14,
    parameter int CUR_END      = 15,
`endif
    parameter int BLINK_FRAMES = 60,
    localparam int CW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1,
    localparam int RW = (CHAR_H > 1) ? $clog2(CHAR_H) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef TEXTMODE_TIMING_CURSOR_EN
    input  logic [COL_W-1:0] cur_col,
    input  logic [ROW_W-1:0] cur_row,
    input  logic             cur_on,
    output logic             cursor,
`endif
    output logic             pix_en,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [COL_W-1:0] txtcol,
    output logic [ROW_W-1:0] txtrow,
    output logic [CW-1:0]    chrcol,
    output logic [RW-1:0]    chrrow,
    output logic             line_start,
    output logic             frame_start,
    output logic             blink
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int PW      = $clog2(PIX_DIV + 1);
    localparam int BW      = $clog2(BLINK_FRAMES);

    // running is clear for the first edge after reset so that edge loads
    // position (0,0) instead of advancing past it.
    logic             running;
    logic [PW-1:0]    pdiv,  n_pdiv;
    logic [HW-1:0]    hcnt,  n_hcnt;
    logic [VW-1:0]    vcnt,  n_vcnt;
    logic [BW-1:0]    bcnt,  n_bcnt;
    logic [CW-1:0]    n_chrcol;
    logic [COL_W-1:0] n_txtcol;
    logic [RW-1:0]    n_chrrow;
    logic [ROW_W-1:0] n_txtrow;
    logic             n_de, n_hs, n_vs, n_blink;

    // Next position. Cell coordinates are tracked incrementally (no divide):
    // the column pair steps with each active pixel, the row pair with each
    // active line, and both are forced to 0 outside their active range.
    always_comb begin
        n_pdiv   = pdiv;
        n_hcnt   = hcnt;
        n_vcnt   = vcnt;
        n_bcnt   = bcnt;
        n_chrcol = chrcol;
        n_txtcol = txtcol;
        n_chrrow = chrrow;
        n_txtrow = txtrow;
        if (!running) begin
            n_pdiv   = '0;
            n_hcnt   = '0;
            n_vcnt   = '0;
            n_bcnt   = '0;
            n_chrcol = '0;
            n_txtcol = '0;
            n_chrrow = '0;
            n_txtrow = '0;
        end else if (pdiv == PW'(PIX_DIV - 1)) begin
            n_pdiv = '0;
            if (hcnt == HW'(H_TOTAL - 1)) begin
                n_hcnt   = '0;
                n_chrcol = '0;
                n_txtcol = '0;
                if (vcnt == VW'(V_TOTAL - 1)) begin
                    n_vcnt = '0;
                    n_bcnt = (bcnt == BW'(BLINK_FRAMES - 1)) ? '0 : bcnt + 1'b1;
                end else begin
                    n_vcnt = vcnt + 1'b1;
                end
                if (n_vcnt == '0 || n_vcnt >= VW'(V_ACTIVE)) begin
                    n_chrrow = '0;
                    n_txtrow = '0;
                end else if (chrrow == RW'(CHAR_H - 1)) begin
                    n_chrrow = '0;
                    n_txtrow = txtrow + 1'b1;
                end else begin
                    n_chrrow = chrrow + 1'b1;
                end
            end else begin
                n_hcnt = hcnt + 1'b1;
                if (n_hcnt >= HW'(H_ACTIVE)) begin
                    n_chrcol = '0;
                    n_txtcol = '0;
                end else if (chrcol == CW'(CHAR_W - 1)) begin
                    n_chrcol = '0;
                    n_txtcol = txtcol + 1'b1;
                end else begin
                    n_chrcol = chrcol + 1'b1;
                end
            end
        end else begin
            n_pdiv = pdiv + 1'b1;
        end
    end

    always_comb begin
        n_de    = (n_hcnt < HW'(H_ACTIVE)) && (n_vcnt < VW'(V_ACTIVE));
        n_hs    = (n_hcnt >= HW'(H_ACTIVE + H_FP)) &&
                  (n_hcnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
        // vcnt only moves on the hcnt wrap, so vsync only changes at hcnt==0
        n_vs    = (n_vcnt >= VW'(V_ACTIVE + V_FP)) &&
                  (n_vcnt <  VW'(V_ACTIVE + V_FP + V_SYNC));
        n_blink = n_bcnt < BW'(BLINK_FRAMES / 2);
    end

`ifdef TEXTMODE_TIMING_CURSOR_EN
    logic n_cursor;
    always_comb begin
        n_cursor = n_de && cur_on && (n_txtcol == cur_col) && (n_txtrow == cur_row) &&
                   (int'(n_chrrow) >= CUR_START) && (int'(n_chrrow) <= CUR_END) &&
                   n_blink;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running     <= 1'b0;
            pdiv        <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            bcnt        <= '0;
            txtcol      <= '0;
            txtrow      <= '0;
            chrcol      <= '0;
            chrrow      <= '0;
            pix_en      <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            blink       <= 1'b1;
`ifdef TEXTMODE_TIMING_CURSOR_EN
            cursor      <= 1'b0;
`endif
        end else begin
            running     <= 1'b1;
            pdiv        <= n_pdiv;
            hcnt        <= n_hcnt;
            vcnt        <= n_vcnt;
            bcnt        <= n_bcnt;
            txtcol      <= n_txtcol;
            txtrow      <= n_txtrow;
            chrcol      <= n_chrcol;
            chrrow      <= n_chrrow;
            pix_en      <= (n_pdiv == PW'(PIX_DIV - 1));
            de          <= n_de;
            hsync       <= n_hs ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= n_vs ? VSYNC_POL : ~VSYNC_POL;
            line_start  <= (n_hcnt == '0);
            frame_start <= (n_hcnt == '0) && (n_vcnt == '0);
            blink       <= n_blink;
`ifdef TEXTMODE_TIMING_CURSOR_EN
            cursor      <= n_cursor;
`endif
        end
    end

endmodule

// File: tb/tb_textmode_timing_gen.sv
// tb_textmode_timing_gen
//   Self-checking bench for textmode_timing_gen on a small raster
//   (H_TOTAL=26, V_TOTAL=8, PIX_DIV=2, 3x3 cells, 2-bit txtcol so the column
//   index truncates, positive hsync / negative vsync, 4-frame blink).
//   Hand-derived vector table, hand sequences for reset and cursor, and a
//   free-running comparison against an arithmetic reference model.
module tb_textmode_timing_gen;

    localparam int PD    = 2;
    localparam int HA    = 20;
    localparam int HFP   = 2;
    localparam int HS    = 3;
    localparam int HBP   = 1;
    localparam int VA    = 5;
    localparam int VFP   = 1;
    localparam int VS    = 1;
    localparam int VBP   = 1;
    localparam bit HPOL  = 1'b1;
    localparam bit VPOL  = 1'b0;
    localparam int CHW   = 3;
    localparam int CHH   = 3;
    localparam int COL_W = 2;
    localparam int ROW_W = 2;
    localparam int BF    = 4;
    localparam int CUR_S = 0;
    localparam int CUR_E = 1;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT * PD;
    localparam int CW    = (CHW > 1) ? $clog2(CHW) : 1;
    localparam int RW    = (CHH > 1) ? $clog2(CHH) : 1;
`ifdef TEXTMODE_TIMING_CURSOR_EN
    localparam bit HAS_CUR = 1'b1;
`else
    localparam bit HAS_CUR = 1'b0;
`endif

    typedef struct packed {
        logic             pix_en;
        logic             de;
        logic             hsync;
        logic             vsync;
        logic [COL_W-1:0] txtcol;
        logic [CW-1:0]    chrcol;
        logic [ROW_W-1:0] txtrow;
        logic [RW-1:0]    chrrow;
        logic             line_start;
        logic             frame_start;
        logic             blink;
        logic             cursor;
    } obs_t;

    typedef struct {
        int   k;
        logic pe, de, hs, vs;
        int   tc, cc, tr, cr;
        logic ls, fs, bl;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             cur_on;
    logic             cursor;
    logic             pix_en, de, hsync, vsync, line_start, frame_start, blink;
    logic [COL_W-1:0] txtcol;
    logic [ROW_W-1:0] txtrow;
    logic [CW-1:0]    chrcol;
    logic [RW-1:0]    chrrow;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   k_cnt   = -1;
    bit   chk_on  = 1'b0;
    obs_t act;
    vec_t tbl [22];

    // ---------------- clock / reset-relative cycle index ----------------
    always #5 clk = ~clk;

    // k_cnt = clocks since the first edge that saw rst_n=1 (that edge is 0);
    // -1 while the last edge sampled reset.
    always @(posedge clk) begin
        if (!rst_n) k_cnt <= -1;
        else        k_cnt <= k_cnt + 1;
    end

    textmode_timing_gen #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CHAR_W(CHW), .CHAR_H(CHH),
        .COL_W(COL_W), .ROW_W(ROW_W),
`ifdef TEXTMODE_TIMING_CURSOR_EN
        .CUR_START(CUR_S), .CUR_END(CUR_E),
`endif
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef TEXTMODE_TIMING_CURSOR_EN
        .cur_col(cur_col),
        .cur_row(cur_row),
        .cur_on(cur_on),
        .cursor(cursor),
`endif
        .pix_en(pix_en),
        .de(de),
        .hsync(hsync),
        .vsync(vsync),
        .txtcol(txtcol),
        .txtrow(txtrow),
        .chrcol(chrcol),
        .chrrow(chrrow),
        .line_start(line_start),
        .frame_start(frame_start),
        .blink(blink)
    );

`ifndef TEXTMODE_TIMING_CURSOR_EN
    assign cursor = 1'b0;
`endif

    always_comb begin
        act.pix_en      = pix_en;
        act.de          = de;
        act.hsync       = hsync;
        act.vsync       = vsync;
        act.txtcol      = txtcol;
        act.chrcol      = chrcol;
        act.txtrow      = txtrow;
        act.chrrow      = chrrow;
        act.line_start  = line_start;
        act.frame_start = frame_start;
        act.blink       = blink;
        act.cursor      = cursor;
    end

    // ---------------- reference model ----------------
    // Position from elapsed clocks with plain division / modulo.
    function automatic obs_t model(int k, logic [COL_W-1:0] ccol,
                                   logic [ROW_W-1:0] crow, logic con);
        obs_t o;
        int p, pd, h, ln, v, fr;
        o = '0;
        if (k < 0) begin
            o.hsync = ~HPOL;
            o.vsync = ~VPOL;
            o.blink = 1'b1;
            return o;
        end
        p  = k / PD;
        pd = k % PD;
        h  = p % HT;
        ln = p / HT;
        v  = ln % VT;
        fr = ln / VT;
        o.pix_en = (pd == PD - 1);
        o.de     = (h < HA) && (v < VA);
        o.hsync  = (h >= HA + HFP && h < HA + HFP + HS) ? HPOL : ~HPOL;
        o.vsync  = (v >= VA + VFP && v < VA + VFP + VS) ? VPOL : ~VPOL;
        if (h < HA) begin
            o.txtcol = COL_W'(h / CHW);
            o.chrcol = CW'(h % CHW);
        end
        if (v < VA) begin
            o.txtrow = ROW_W'(v / CHH);
            o.chrrow = RW'(v % CHH);
        end
        o.line_start  = (h == 0);
        o.frame_start = (h == 0) && (v == 0);
        o.blink       = (fr % BF) < (BF / 2);
        o.cursor      = HAS_CUR && o.de && con && (o.txtcol == ccol) &&
                        (o.txtrow == crow) && (int'(o.chrrow) >= CUR_S) &&
                        (int'(o.chrrow) <= CUR_E) && o.blink;
        return o;
    endfunction

    // Free-running comparison every clock against the model.
    always @(posedge clk) begin
        obs_t e;
        #1;
        if (chk_on) begin
            e = model(k_cnt, cur_col, cur_row, cur_on);
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL model_cmp k=%0d actual=%h expected=%h", k_cnt, act, e);
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check_obs(input string name, input obs_t e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, e);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        n_tests++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, a, e);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(int k, logic pe, logic d, logic hs, logic vs,
                                int tc, int cc, int tr, int cr,
                                logic ls, logic fs, logic bl);
        vec_t r;
        r.k = k; r.pe = pe; r.de = d; r.hs = hs; r.vs = vs;
        r.tc = tc; r.cc = cc; r.tr = tr; r.cr = cr;
        r.ls = ls; r.fs = fs; r.bl = bl;
        return r;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        obs_t e;
        int   cnt;
        int   guard;
        int   rst_left;

        //               k    pe de hs vs tc cc tr cr ls fs bl
        tbl[0]  = mk(   0,   0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        tbl[1]  = mk(   1,   1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        tbl[2]  = mk(   2,   0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1);
        tbl[3]  = mk(   7,   1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(  38,   0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 1);
        tbl[5]  = mk(  40,   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(  44,   0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(  49,   1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[8]  = mk(  50,   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[9]  = mk(  52,   0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1);
        tbl[10] = mk( 166,   0, 1, 0, 1, 1, 2, 1, 0, 0, 0, 1);
        tbl[11] = mk( 208,   0, 1, 0, 1, 0, 0, 1, 1, 1, 0, 1);
        tbl[12] = mk( 250,   0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1);
        tbl[13] = mk( 260,   0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        tbl[14] = mk( 312,   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        tbl[15] = mk( 363,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[16] = mk( 364,   0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        tbl[17] = mk( 416,   0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        tbl[18] = mk( 831,   1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[19] = mk( 832,   0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        tbl[20] = mk(1663,   1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(1664,   0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1);

        rst_n   = 1'b0;
        cur_col = '0;
        cur_row = '0;
        cur_on  = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;

        // reset state
        e = '0;
        e.hsync = ~HPOL;
        e.vsync = ~VPOL;
        e.blink = 1'b1;
        check_obs("reset_state", e);

        // table-driven vectors from release
        rst_n = 1'b1;
        for (int i = 0; i < 22; i++) begin
            guard = 0;
            while (k_cnt != tbl[i].k && guard < 4000) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 4000) begin
                check_int("vec_timeout", k_cnt, tbl[i].k);
            end else begin
                e = '0;
                e.pix_en      = tbl[i].pe;
                e.de          = tbl[i].de;
                e.hsync       = tbl[i].hs;
                e.vsync       = tbl[i].vs;
                e.txtcol      = COL_W'(tbl[i].tc);
                e.chrcol      = CW'(tbl[i].cc);
                e.txtrow      = ROW_W'(tbl[i].tr);
                e.chrrow      = RW'(tbl[i].cr);
                e.line_start  = tbl[i].ls;
                e.frame_start = tbl[i].fs;
                e.blink       = tbl[i].bl;
                check_obs($sformatf("vec_k%0d", tbl[i].k), e);
            end
        end

`ifdef TEXTMODE_TIMING_CURSOR_EN
        // cursor on cell (1,1), scan lines 0..1; txtcol 5 aliases to 1 in 2 bits
        @(negedge clk);
        rst_n   = 1'b0;
        cur_col = 2'd1;
        cur_row = 2'd1;
        cur_on  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(posedge clk);
            #1;
            if (cursor) cnt++;
        end
        check_int("cursor_frame0_cycles", cnt, 24);
        repeat (FRAME) @(posedge clk);
        cnt = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(posedge clk);
            #1;
            if (cursor) cnt++;
        end
        check_int("cursor_frame2_blink_off", cnt, 0);
        @(negedge clk);
        cur_on = 1'b0;
`endif

        // reset mid-frame, 3 clocks low, then restart at (0,0)
        do_reset(2);
        repeat (200) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        e = '0;
        e.hsync = ~HPOL;
        e.vsync = ~VPOL;
        e.blink = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_obs($sformatf("midreset_hold%0d", c), e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        e = '0;
        e.pix_en      = (PD == 1);
        e.de          = 1'b1;
        e.hsync       = ~HPOL;
        e.vsync       = ~VPOL;
        e.line_start  = 1'b1;
        e.frame_start = 1'b1;
        e.blink       = 1'b1;
        check_obs("midreset_restart", e);

        // randomized cursor inputs and occasional reset pulses
        rst_left = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (!rst_n) begin
                if (rst_left == 0) rst_n = 1'b1;
                else rst_left--;
            end else if ($urandom_range(0, 2499) == 0) begin
                rst_n    = 1'b0;
                rst_left = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 31) == 0) begin
                cur_col = COL_W'($urandom);
                cur_row = ROW_W'($urandom_range(0, 1));
                cur_on  = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/textmode_timing_gen.md
Name: textmode_timing_gen

Overview:
Parametrised raster timing generator for the text-mode display path. It replaces the fixed 640x480 / 8x16-cell timing block. The block produces a pixel-enable strobe, display enable, programmable-polarity syncs, text cell and in-cell coordinates for any cell width or height, line and frame strobes, and a blink phase. It sits between the system clock and the character ROM / attribute pipeline.

Parameters:
PIX_DIV, 2, clk cycles per pixel (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted hsync level
VSYNC_POL, 0, asserted vsync level
CHAR_W, 8, pixels per cell (>=1; need not be a power of 2)
CHAR_H, 16, lines per cell (>=1; need not be a power of 2)
COL_W, 7, txtcol width
ROW_W, 5, txtrow width
BLINK_FRAMES, 60, blink period in frames (even, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pix_en  out  1  high in last clk of each pixel period
de  out  1  display enable (active pixel)
hsync  out  1  horizontal sync, polarity HSYNC_POL
vsync  out  1  vertical sync, polarity VSYNC_POL
txtcol  out  COL_W  text column
txtrow  out  ROW_W  text row
chrcol  out  clog2(CHAR_W) (min 1)  pixel within cell
chrrow  out  clog2(CHAR_H) (min 1)  line within cell
line_start  out  1  position hcnt==0
frame_start  out  1  position hcnt==0 and vcnt==0
blink  out  1  blink phase

Behaviour:
- Reset is synchronous and active-low on rst_n; single clock clk.
- H_TOTAL = sum of H params; V_TOTAL = sum of V params. Internal hcnt 0..H_TOTAL-1, vcnt 0..V_TOTAL-1, pdiv 0..PIX_DIV-1.
- While rst_n=0: pix_en=0, de=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, txt*/chr*=0, line_start=frame_start=0, blink=1; counters 0.
- First edge with rst_n=1: position (0,0), pdiv=0. All outputs then decode position (0,0).
- Each position is held exactly PIX_DIV clk cycles. pix_en=1 only when pdiv==PIX_DIV-1; position advances on that edge. PIX_DIV=1 gives pix_en constantly 1 after reset.
- hcnt wraps H_TOTAL-1 -> 0. vcnt increments on hcnt wrap and wraps V_TOTAL-1 -> 0.
- All outputs are registered and always reflect the current position; zero latency and glitch-free (decode from next-state).
- de = (hcnt < H_ACTIVE) and (vcnt < V_ACTIVE).
- hsync is asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC; it changes only at hcnt==0.
- chrcol counts 0..CHAR_W-1 across active pixels; on wrap, txtcol increments.
- chrrow counts 0..CHAR_H-1 per active line; on wrap, txtrow increments.
- In horizontal blanking, txtcol=chrcol=0. In vertical blanking, txtrow=chrrow=0.
- A partial last cell is allowed (H_ACTIVE need not be a multiple of CHAR_W, same for V). txt* values truncate to COL_W/ROW_W.
- line_start and frame_start are level signals for the whole pixel period; consumers qualify them with pix_en.
- Blink counter 0..BLINK_FRAMES-1 advances on the last pixel of each frame. blink=1 while count < BLINK_FRAMES/2, else 0.
- Reset mid-operation: next edge loads reset values; restart at (0,0) with blink count 0.

Optional Feature:
TEXTMODE_TIMING_CURSOR_EN
- Defined: adds parameters CUR_START (default 14) and CUR_END (default 15), inputs cur_col[COL_W], cur_row[ROW_W], cur_on, and output cursor.
- cursor=1 iff de and cur_on and txtcol==cur_col and txtrow==cur_row and CUR_START<=chrrow<=CUR_END and blink=1.
- cursor is registered and aligned with de; it is 0 in reset.
- Undefined: none of these ports or parameters exist; everything else is unchanged.

Test Plan:
1. Defaults, PIX_DIV=2 -> line period 1600 clk, frame 525 lines; hsync low 192 clk starting 1312 clk after line_start rises; vsync low during lines 490-491 only.
2. Defaults -> de high 640 pixels x 480 lines per frame; txtcol 0..79, chrcol 0..7, txtrow 0..29, chrrow 0..15; all zero when de=0.
3. CHAR_W=9, H_ACTIVE=720, H_FP=18, H_SYNC=108, H_BP=54, PIX_DIV=1 -> chrcol 0..8; txtcol reaches 79 with chrcol=8 at hcnt=719.
4. HSYNC_POL=1, VSYNC_POL=1, H_ACTIVE=20, H_FP=2, H_SYNC=3, H_BP=1 -> hsync high only at hcnt 22..24; idle low.
5. BLINK_FRAMES=4, small frame (H_TOTAL=26, V_TOTAL=8) -> blink 1 in frames 0-1, 0 in frames 2-3; toggles coincide with frame_start.
6. rst_n low 3 clk at hcnt=300, vcnt=100 -> reset values during reset; first cycle after release frame_start=1, de=1, position (0,0). With TEXTMODE_TIMING_CURSOR_EN, cur_col=5, cur_row=2, cur_on=1 -> cursor high on hcnt 40..47 of lines 46..47 while blink=1.
